// File: rtl/inst_queue_dual_pkg.sv
// inst_queue_dual_pkg
// Shared constants and helpers for the dual-issue instruction queue.
// Contents:
//   IQ_DEPTH / IQ_PTR_W / IQ_AF_SLACK - default geometry of the queue
//   INST_WIDTH / ADDR_WIDTH           - default instruction and PC widths
//   TRUE / FALSE                      - single-bit truth constants
//   deq_cnt_t                         - decoder consume-count type
//   clamp_deq()                       - limits a consume request to what is held
package inst_queue_dual_pkg;

  localparam int IQ_DEPTH    = 16;
  localparam int IQ_PTR_W    = $clog2(IQ_DEPTH) + 1;
  localparam int IQ_AF_SLACK = 2;
  localparam int INST_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [1:0] deq_cnt_t;

  // A request of 3 is treated as 2, and the result never exceeds the
  // number of valid entries, so the head pointer can never pass the tail.
  function automatic deq_cnt_t clamp_deq(input deq_cnt_t req,
                                         input logic     has_one,
                                         input logic     has_two);
    deq_cnt_t n;
    n = 2'd0;
    if (req != 2'd0 && has_one == TRUE) begin
      if (has_two == FALSE || req == 2'd1) begin
        n = 2'd1;
      end else begin
        n = 2'd2;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/inst_queue_dual_if.sv
// inst_queue_dual_if
// Bundles every non-clock/reset signal of the instruction queue.
// Modports:
//   slave  - the queue itself (consumes IF/decoder/ROB controls, drives status and read ports)
//   master - the surrounding pipeline (or a bench) driving the controls
// Signals:
//   rdy_in              global enable
//   inst_if_in/pc_if_in fetched instruction and its PC, rdy_inst_if_in = enqueue valid
//   iq_full_if_out      almost-full back to IF, ovf_err_out = sticky overflow
//   inst0/pc0/rdy0      oldest entry, inst1/pc1/rdy1 = second-oldest entry
//   deq_cnt_dec_in      entries consumed by the decoder this cycle
//   count_out           current occupancy
//   refresh_rob_cdb_in  flush on misprediction
interface inst_queue_dual_if
  import inst_queue_dual_pkg::*;
#(
  parameter int INST_W = INST_WIDTH,
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int CNT_W  = IQ_PTR_W
);

  logic              rdy_in;
  logic [INST_W-1:0] inst_if_in;
  logic [ADDR_W-1:0] pc_if_in;
  logic              rdy_inst_if_in;
  logic              iq_full_if_out;
  logic              ovf_err_out;
  logic [INST_W-1:0] inst0_dec_out;
  logic [ADDR_W-1:0] pc0_dec_out;
  logic              rdy0_dec_out;
  logic [INST_W-1:0] inst1_dec_out;
  logic [ADDR_W-1:0] pc1_dec_out;
  logic              rdy1_dec_out;
  deq_cnt_t          deq_cnt_dec_in;
  logic [CNT_W-1:0]  count_out;
  logic              refresh_rob_cdb_in;

  modport slave (
    input  rdy_in, inst_if_in, pc_if_in, rdy_inst_if_in,
    input  deq_cnt_dec_in, refresh_rob_cdb_in,
    output iq_full_if_out, ovf_err_out,
    output inst0_dec_out, pc0_dec_out, rdy0_dec_out,
    output inst1_dec_out, pc1_dec_out, rdy1_dec_out,
    output count_out
  );

  modport master (
    output rdy_in, inst_if_in, pc_if_in, rdy_inst_if_in,
    output deq_cnt_dec_in, refresh_rob_cdb_in,
    input  iq_full_if_out, ovf_err_out,
    input  inst0_dec_out, pc0_dec_out, rdy0_dec_out,
    input  inst1_dec_out, pc1_dec_out, rdy1_dec_out,
    input  count_out
  );

endinterface

// File: rtl/inst_queue_dual_storage.sv
// iq_storage
// Entry array for the instruction queue: DEPTH words of WIDTH bits,
// one synchronous write port and two asynchronous read ports. The array
// is deliberately not reset; validity is tracked by the pointers.
// Ports:
//   clk_in            clock
//   wr_en/wr_idx/wr_data  write port
//   rd_idx0/rd_data0  read port for the oldest entry
//   rd_idx1/rd_data1  read port for the second-oldest entry
module iq_storage
  import inst_queue_dual_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = INST_WIDTH + ADDR_WIDTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx0,
  output logic [WIDTH-1:0] rd_data0,
  input  logic [IDX_W-1:0] rd_idx1,
  output logic [WIDTH-1:0] rd_data1
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Plain register file write; no reset so it maps onto cheap flops.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data0 = mem[rd_idx0];
  assign rd_data1 = mem[rd_idx1];

endmodule

// File: rtl/inst_queue_dual.sv
// inst_queue_dual
// Circular instruction queue between IF and a dual-issue decoder. Holds
// instruction/PC pairs, exposes the two oldest to the decoder, which may
// consume 0..2 per cycle, signals almost-full to IF and flushes on a ROB
// refresh.
// Ports:
//   clk_in  clock
//   rst_in  asynchronous active-high reset
//   bus     inst_queue_dual_if.slave carrying all handshake/data signals
module inst_queue_dual
  import inst_queue_dual_pkg::*;
#(
  parameter int DEPTH    = IQ_DEPTH,
  parameter int INST_W   = INST_WIDTH,
  parameter int ADDR_W   = ADDR_WIDTH,
  parameter int AF_SLACK = IQ_AF_SLACK
) (
  input  logic             clk_in,
  input  logic             rst_in,
  inst_queue_dual_if.slave bus
);

  localparam int IDX_W   = $clog2(DEPTH);
  localparam int PTR_W   = IDX_W + 1;
  localparam int ENTRY_W = INST_W + ADDR_W;
  localparam logic [PTR_W-1:0] FULL_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_CNT   = PTR_W'(DEPTH - AF_SLACK);

  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   count;
  logic               ovf;
  logic               full;
  logic               has_one;
  logic               has_two;
  logic               active;
  logic               flush;
  logic               enq_fire;
  logic               ovf_set;
  deq_cnt_t           deq_n;
  logic [IDX_W-1:0]   rd_idx0;
  logic [IDX_W-1:0]   rd_idx1;
  logic [ENTRY_W-1:0] rd_data0;
  logic [ENTRY_W-1:0] rd_data1;

  // The extra pointer MSB lets tail - head distinguish full from empty,
  // so every slot is usable and wrap needs no special case.
  assign count   = tail - head;
  assign full    = (count == FULL_CNT);
  assign has_one = (count != '0);
  assign has_two = (count >= PTR_W'(2));

  // Refresh dominates; enqueue is judged only on the registered count, so
  // a same-cycle dequeue never makes room for an enqueue at full.
  assign active   = bus.rdy_in;
  assign flush    = active && bus.refresh_rob_cdb_in;
  assign enq_fire = active && !flush && bus.rdy_inst_if_in && !full;
  assign ovf_set  = active && !flush && bus.rdy_inst_if_in && full;
  assign deq_n    = (active && !flush)
                  ? clamp_deq(bus.deq_cnt_dec_in, has_one, has_two)
                  : 2'd0;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head <= '0;
      tail <= '0;
      ovf  <= 1'b0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      ovf  <= 1'b0;
    end else begin
      if (enq_fire) begin
        tail <= tail + PTR_W'(1);
      end
      head <= head + PTR_W'(deq_n);
      if (ovf_set) begin
        ovf <= 1'b1;
      end
    end
  end

  assign rd_idx0 = head[IDX_W-1:0];
  assign rd_idx1 = rd_idx0 + IDX_W'(1);

  iq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .IDX_W (IDX_W)
  ) u_storage (
    .clk_in   (clk_in),
    .wr_en    (enq_fire),
    .wr_idx   (tail[IDX_W-1:0]),
    .wr_data  ({bus.inst_if_in, bus.pc_if_in}),
    .rd_idx0  (rd_idx0),
    .rd_data0 (rd_data0),
    .rd_idx1  (rd_idx1),
    .rd_data1 (rd_data1)
  );

  assign bus.inst0_dec_out  = rd_data0[ENTRY_W-1:ADDR_W];
  assign bus.pc0_dec_out    = rd_data0[ADDR_W-1:0];
  assign bus.rdy0_dec_out   = has_one;
  assign bus.inst1_dec_out  = rd_data1[ENTRY_W-1:ADDR_W];
  assign bus.pc1_dec_out    = rd_data1[ADDR_W-1:0];
  assign bus.rdy1_dec_out   = has_two;
  assign bus.count_out      = count;
  assign bus.iq_full_if_out = (count >= AF_CNT);
  assign bus.ovf_err_out    = ovf;

endmodule

// File: tb/tb_inst_queue_dual.sv
// tb_inst_queue_dual
// Directed bench for inst_queue_dual at DEPTH=8, AF_SLACK=2. Accepted
// enqueues push their expected {inst,pc} into a scoreboard; a negedge
// monitor compares the decoder ports whenever entries are consumed.
// Status outputs are compared against hand-computed constants.
module tb_inst_queue_dual;
  import inst_queue_dual_pkg::*;

  localparam int DEPTH    = 8;
  localparam int AF_SLACK = 2;
  localparam int CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [31:0] INST_XOR = 32'hDEAD_0000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fails;
  logic [63:0] sb [$];

  inst_queue_dual_if #(.INST_W(32), .ADDR_W(32), .CNT_W(CNT_W)) bus ();

  inst_queue_dual #(
    .DEPTH    (DEPTH),
    .INST_W   (32),
    .ADDR_W   (32),
    .AF_SLACK (AF_SLACK)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted always, reported only on disagreement.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of controls, let one edge pass, then record what the
  // queue is expected to hold afterwards.
  task automatic applyStimulus(input logic rdy, input logic enq, input logic [31:0] pc,
                               input logic [1:0] deq, input logic refresh,
                               input logic accept);
    bus.rdy_in             = rdy;
    bus.rdy_inst_if_in     = enq;
    bus.pc_if_in           = pc;
    bus.inst_if_in         = pc ^ INST_XOR;
    bus.deq_cnt_dec_in     = deq;
    bus.refresh_rob_cdb_in = refresh;
    @(posedge clk);
    #1;
    if (accept) sb.push_back({pc ^ INST_XOR, pc});
    if (refresh && rdy) sb.delete();
    bus.rdy_in             = 1'b1;
    bus.rdy_inst_if_in     = 1'b0;
    bus.deq_cnt_dec_in     = 2'd0;
    bus.refresh_rob_cdb_in = 1'b0;
  endtask

  // Monitor: valid flags must track the scoreboard depth, and every
  // consumed entry must match the oldest expected entry in order.
  always @(negedge clk) begin
    if (!rst) begin
      int req;
      int n;
      logic [63:0] exp_e;
      checkOutput("rdy0", 32'(bus.rdy0_dec_out), 32'(sb.size() >= 1));
      checkOutput("rdy1", 32'(bus.rdy1_dec_out), 32'(sb.size() >= 2));
      if (bus.rdy_in && !bus.refresh_rob_cdb_in) begin
        req = (bus.deq_cnt_dec_in == 2'd3) ? 2 : int'(bus.deq_cnt_dec_in);
        n   = (req < sb.size()) ? req : sb.size();
        for (int j = 0; j < n; j++) begin
          exp_e = sb.pop_front();
          if (j == 0) begin
            checkOutput("pc0_deq", bus.pc0_dec_out, exp_e[31:0]);
            checkOutput("inst0_deq", bus.inst0_dec_out, exp_e[63:32]);
          end else begin
            checkOutput("pc1_deq", bus.pc1_dec_out, exp_e[31:0]);
            checkOutput("inst1_deq", bus.inst1_dec_out, exp_e[63:32]);
          end
        end
      end
    end
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    bus.rdy_in             = 1'b1;
    bus.rdy_inst_if_in     = 1'b0;
    bus.pc_if_in           = '0;
    bus.inst_if_in         = '0;
    bus.deq_cnt_dec_in     = 2'd0;
    bus.refresh_rob_cdb_in = 1'b0;
    #12;
    checkOutput("reset_count", 32'(bus.count_out), 0);
    checkOutput("reset_iq_full", 32'(bus.iq_full_if_out), 0);
    checkOutput("reset_ovf", 32'(bus.ovf_err_out), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to DEPTH; almost-full must rise once count reaches 6.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b1, 32'(i * 4), 2'd0, 1'b0, 1'b1);
      checkOutput("fill_iq_full", 32'(bus.iq_full_if_out), 32'((i + 1) >= 6));
    end
    checkOutput("fill_count", 32'(bus.count_out), 8);
    applyStimulus(1'b1, 1'b1, 32'h20, 2'd0, 1'b0, 1'b0);
    checkOutput("ovf_count", 32'(bus.count_out), 8);
    checkOutput("ovf_set", 32'(bus.ovf_err_out), 1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 0, 2'd2, 1'b0, 1'b0);
    checkOutput("drain_count", 32'(bus.count_out), 0);
    checkOutput("ovf_sticky", 32'(bus.ovf_err_out), 1);

    // Dual dequeue then clamped dequeue on a single entry.
    applyStimulus(1'b1, 1'b1, 32'h100, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h104, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h108, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 2'd2, 1'b0, 1'b0);
    checkOutput("dual_pc0", bus.pc0_dec_out, 32'h108);
    checkOutput("dual_rdy1", 32'(bus.rdy1_dec_out), 0);
    checkOutput("dual_count", 32'(bus.count_out), 1);
    applyStimulus(1'b1, 1'b0, 0, 2'd2, 1'b0, 1'b0);
    checkOutput("clamp_count", 32'(bus.count_out), 0);

    // Refresh beats a simultaneous enqueue and dequeue, and clears ovf.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 32'h200 + 32'(i * 4), 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h210, 2'd2, 1'b1, 1'b0);
    checkOutput("refresh_count", 32'(bus.count_out), 0);
    checkOutput("refresh_ovf", 32'(bus.ovf_err_out), 0);
    applyStimulus(1'b1, 1'b1, 32'h300, 2'd0, 1'b0, 1'b1);
    checkOutput("post_refresh_pc0", bus.pc0_dec_out, 32'h300);
    checkOutput("post_refresh_count", 32'(bus.count_out), 1);
    applyStimulus(1'b1, 1'b0, 0, 2'd1, 1'b0, 1'b0);

    // Steady enqueue+dequeue across the pointer wrap.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h400 + 32'(i * 4), 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h40C + 32'(i * 4), 2'd1, 1'b0, 1'b1);
      checkOutput("wrap_count", 32'(bus.count_out), 3);
    end
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 32'h45C + 32'(i * 4), 2'd0, 1'b0, 1'b1);
    checkOutput("full_count", 32'(bus.count_out), 8);
    checkOutput("full_iq_full", 32'(bus.iq_full_if_out), 1);
    applyStimulus(1'b1, 1'b1, 32'h999, 2'd1, 1'b0, 1'b0);
    checkOutput("full_simul_count", 32'(bus.count_out), 7);
    checkOutput("full_simul_ovf", 32'(bus.ovf_err_out), 1);
    applyStimulus(1'b1, 1'b0, 0, 2'd3, 1'b0, 1'b0);
    checkOutput("deq3_count", 32'(bus.count_out), 5);
    applyStimulus(1'b1, 1'b0, 0, 2'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 2'd3, 1'b0, 1'b0);
    checkOutput("deq3_count_b", 32'(bus.count_out), 1);
    applyStimulus(1'b1, 1'b0, 0, 2'd3, 1'b0, 1'b0);
    checkOutput("deq3_clamp_count", 32'(bus.count_out), 0);

    // Stall: nothing may move while rdy_in is low.
    applyStimulus(1'b1, 1'b1, 32'h500, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h504, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 32'h508, 2'd2, 1'b0, 1'b0);
      checkOutput("stall_count", 32'(bus.count_out), 2);
      checkOutput("stall_pc0", bus.pc0_dec_out, 32'h500);
      checkOutput("stall_pc1", bus.pc1_dec_out, 32'h504);
    end
    applyStimulus(1'b1, 1'b1, 32'h50C, 2'd1, 1'b0, 1'b1);
    checkOutput("resume_count", 32'(bus.count_out), 2);
    checkOutput("resume_pc0", bus.pc0_dec_out, 32'h504);
    checkOutput("resume_pc1", bus.pc1_dec_out, 32'h50C);

    // Asynchronous reset with 5 entries queued.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 32'h510 + 32'(i * 4), 2'd0, 1'b0, 1'b1);
    checkOutput("pre_reset_count", 32'(bus.count_out), 5);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    checkOutput("async_count", 32'(bus.count_out), 0);
    checkOutput("async_rdy0", 32'(bus.rdy0_dec_out), 0);
    checkOutput("async_rdy1", 32'(bus.rdy1_dec_out), 0);
    checkOutput("async_iq_full", 32'(bus.iq_full_if_out), 0);
    checkOutput("async_ovf", 32'(bus.ovf_err_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 32'h600, 2'd0, 1'b0, 1'b1);
    checkOutput("post_reset_pc0", bus.pc0_dec_out, 32'h600);
    checkOutput("post_reset_count", 32'(bus.count_out), 1);
    applyStimulus(1'b1, 1'b0, 0, 2'd1, 1'b0, 1'b0);
    checkOutput("final_count", 32'(bus.count_out), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/inst_queue_dual.md
Name: inst_queue_dual

Overview:
Parametrised instruction queue between IF and the decoder, replacing the single-issue queue. It holds fetched instruction/PC pairs in a circular buffer with exact occupancy tracking. It presents the two oldest entries to the decoder, which may consume 0, 1 or 2 per cycle. IF sees a configurable almost-full threshold, and a ROB refresh flushes the whole queue.

Parameters:
DEPTH, 16, entry count; power of two, >= 4
INST_W, 32, instruction width
ADDR_W, 32, PC width
AF_SLACK, 2, free slots reserved for IF in-flight fetches; 1 <= AF_SLACK < DEPTH

Ports:
clk_in  in  1  clock
rst_in  in  1  reset, asynchronous, active-high
rdy_in  in  1  global enable; low freezes all state
inst_if_in  in  INST_W  fetched instruction
pc_if_in  in  ADDR_W  PC of fetched instruction
rdy_inst_if_in  in  1  IF enqueue valid
iq_full_if_out  out  1  almost-full to IF
ovf_err_out  out  1  sticky: enqueue was attempted while full
inst0_dec_out  out  INST_W  oldest entry
pc0_dec_out  out  ADDR_W  PC of oldest entry
rdy0_dec_out  out  1  oldest entry valid
inst1_dec_out  out  INST_W  second-oldest entry
pc1_dec_out  out  ADDR_W  PC of second-oldest entry
rdy1_dec_out  out  1  second-oldest entry valid
deq_cnt_dec_in  in  2  entries consumed this cycle (0..2)
count_out  out  log2(DEPTH)+1  current occupancy
refresh_rob_cdb_in  in  1  flush (misprediction)

Behaviour:
- Pointers: head and tail are each log2(DEPTH)+1 bits.
  - count = tail - head, modulo 2^(log2(DEPTH)+1).
  - Full when count == DEPTH; empty when count == 0. All DEPTH slots are usable.
- Reset (asynchronous, rst_in high): head=0, tail=0, ovf_err_out=0. Storage is not reset.
  - While in reset: count_out=0, rdy0/rdy1=0, iq_full_if_out=0.
- rdy_in low: no pointer, storage or flag changes. Combinational outputs still reflect the held state.
- Per-cycle priority when rdy_in is high: refresh, then enqueue/dequeue.
- Refresh:
  - head<=0, tail<=0, ovf_err_out<=0.
  - Enqueue and dequeue in the same cycle are discarded.
- Enqueue fires when rdy_inst_if_in && count < DEPTH, using the registered count.
  - Fire: writes slot tail[log2-1:0], tail<=tail+1.
  - No same-cycle bypass: a dequeue freeing space does not admit an enqueue while count == DEPTH.
  - rdy_inst_if_in while count == DEPTH: entry dropped, ovf_err_out<=1 (stays set until reset or refresh).
- Dequeue: effective n = min(deq_cnt_dec_in, count); value 3 is treated as 2. head<=head+n.
- Simultaneous enqueue and dequeue: both apply; count changes by (enq ? 1 : 0) - n.
- Read outputs are combinational from registered state:
  - Slot 0 is head; slot 1 is (head+1) mod DEPTH.
  - rdy0_dec_out = count >= 1; rdy1_dec_out = count >= 2.
  - Data on invalid ports is don't-care.
- Latency: an entry enqueued at edge k is visible on slot 0/1 after edge k. With an empty queue, it appears on slot 0 in cycle k+1.
- iq_full_if_out = count >= DEPTH - AF_SLACK (combinational from registered count).
- Wrap-around: pointer low bits index storage and the MSB disambiguates full/empty. No special case at DEPTH-1 -> 0.

Decomposition:
- define.vh additions: IQ_DEPTH, IQ_PTR_W (log2(DEPTH)+1), IQ_AF_SLACK, TRUE/FALSE, existing INST_WIDTH/ADDR_WIDTH.
- One sub-module, iq_storage: DEPTH x (INST_W+ADDR_W) register array with 1 synchronous write port and 2 asynchronous read ports. No reset.
- Top level holds pointers, count, flags and clamp logic.

Test Plan:
- Reset/empty: assert rst_in mid-run with 5 entries queued -> count_out=0, rdy0=rdy1=0, iq_full=0 immediately (asynchronous), without waiting for a clock edge.
- Fill (DEPTH=8, AF_SLACK=2):
  - Enqueue PCs 0x00..0x1C, one per cycle, deq=0 -> iq_full rises when count reaches 6; count_out=8 after 8 edges.
  - A 9th enqueue -> dropped, ovf_err_out=1, count stays 8.
- Dual dequeue:
  - 3 entries (PC 0x100,0x104,0x108), deq=2 -> next cycle pc0=0x108, rdy1=0, count=1.
  - Then deq=2 -> clamped; count=0, no underflow.
- Wrap plus simultaneous ops:
  - Cycle 20 entries through DEPTH=8 with enqueue every cycle and deq=1 -> FIFO order preserved across the pointer wrap; count constant.
  - At full with deq=1 and enq=1 -> enqueue rejected, count=7.
- Refresh: 4 entries queued, refresh with enq=1 and deq=2 in the same cycle -> count=0, ovf_err cleared; the next enqueue appears on slot 0 one cycle later.
- Stall: rdy_in=0 for 3 cycles with enq=1 and deq=2 -> count and outputs unchanged; operation resumes correctly when rdy_in=1.
